// File: rtl/lfsr_prng_gen.sv
// ---------------------------------------------------------------------------
// lfsr_prng_gen
//
// Two-layer pseudo-random word generator. A wide "up" Fibonacci LFSR and a
// narrow "down" Fibonacci LFSR, each with a programmable feedback mask, are
// combined by XOR-ing their low OUT_BITS bits. After reset or a runtime seed
// load the generator discards WARMUP steps (WARM state) and then offers one
// word at a time over a valid/ready handshake (RUN state). A word is consumed
// only on a cycle where prng_valid & prng_ready; otherwise the state holds.
//
// Ports:
//   clk          in   1          single clock, rising edge
//   rst          in   1          synchronous active-high reset
//   seed_up      in   UP_BITS    up LFSR seed, sampled with seed_load
//   seed_down    in   DOWN_BITS  down LFSR seed, sampled with seed_load
//   seed_load    in   1          one-cycle seed load request
//   prng_data    out  OUT_BITS   up[OUT_BITS-1:0] ^ down[OUT_BITS-1:0]
//   prng_valid   out  1          prng_data is consumable (RUN)
//   prng_ready   in   1          consumer accepts prng_data
//   warm_busy    out  1          high while discarding warm-up steps
//   period_wrap  out  1          only with LFSR_PERIOD_DET_EN: one-cycle
//                                pulse when a RUN step returns the up LFSR
//                                to the state it held on entering RUN
//
// Optional feature macro: LFSR_PERIOD_DET_EN (period-wrap detector).
// ---------------------------------------------------------------------------
module lfsr_prng_gen #(
  parameter int unsigned              UP_BITS   = 16,
  parameter int unsigned              DOWN_BITS = 8,
  parameter int unsigned              OUT_BITS  = 8,
  parameter logic [UP_BITS-1:0]       UP_TAPS   = 16'hB400,
  parameter logic [DOWN_BITS-1:0]     DOWN_TAPS = 8'hB8,
  parameter logic [UP_BITS-1:0]       UP_INIT   = 16'h00FF,
  parameter logic [DOWN_BITS-1:0]     DOWN_INIT = 8'h0F,
  parameter int unsigned              WARMUP    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UP_BITS-1:0]   seed_up,
  input  logic [DOWN_BITS-1:0] seed_down,
  input  logic                 seed_load,
  output logic [OUT_BITS-1:0]  prng_data,
  output logic                 prng_valid,
  input  logic                 prng_ready,
  output logic                 warm_busy
`ifdef LFSR_PERIOD_DET_EN
  ,
  output logic                 period_wrap
`endif
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if (UP_BITS < 4 || UP_BITS > 32) begin : g_err_up_bits
      $error("lfsr_prng_gen: UP_BITS must be in 4..32");
    end
    if (DOWN_BITS < 4 || DOWN_BITS > UP_BITS) begin : g_err_down_bits
      $error("lfsr_prng_gen: DOWN_BITS must be in 4..UP_BITS");
    end
    if (OUT_BITS < 1 || OUT_BITS > DOWN_BITS) begin : g_err_out_bits
      $error("lfsr_prng_gen: OUT_BITS must be in 1..DOWN_BITS");
    end
    if (WARMUP > 255) begin : g_err_warmup
      $error("lfsr_prng_gen: WARMUP must be in 0..255");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // With no warm-up the generator is usable straight out of reset/load.
  localparam state_t     START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;
  // Counter value on which the final warm-up step is taken.
  localparam logic [7:0] WARM_LAST   = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [UP_BITS-1:0]    up_q, up_d;
  logic [DOWN_BITS-1:0]  down_q, down_d;

  // -------------------------------------------------------------------------
  // LFSR step functions and seed substitution
  // -------------------------------------------------------------------------
  logic                  up_fb, down_fb;
  logic [UP_BITS-1:0]    up_step;
  logic [DOWN_BITS-1:0]  down_step;
  logic [UP_BITS-1:0]    up_seeded;
  logic [DOWN_BITS-1:0]  down_seeded;

  always_comb begin
    up_fb     = ^(up_q & UP_TAPS);
    down_fb   = ^(down_q & DOWN_TAPS);
    up_step   = {up_q[UP_BITS-2:0], up_fb};
    down_step = {down_q[DOWN_BITS-2:0], down_fb};
    // An all-zero seed would lock the LFSR, so the init value replaces it.
    up_seeded   = (seed_up == '0) ? UP_INIT : seed_up;
    down_seeded = (seed_down == '0) ? DOWN_INIT : seed_down;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. seed_load wins over any step; a handshake on the same
  // cycle as a load is therefore not a transfer.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    down_d  = down_q;

    if (seed_load) begin
      up_d    = up_seeded;
      down_d  = down_seeded;
      cnt_d   = '0;
      state_d = START_STATE;
    end else begin
      case (state_q)
        ST_WARM: begin
          up_d   = up_step;
          down_d = down_step;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == WARM_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (prng_ready) begin
            up_d   = up_step;
            down_d = down_step;
          end
        end
        default: begin
          state_d = START_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_STATE;
      cnt_q   <= '0;
      up_q    <= UP_INIT;
      down_q  <= DOWN_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, all decoded directly from registers
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < int'(OUT_BITS); gi++) begin : g_out_xor
      assign prng_data[gi] = up_q[gi] ^ down_q[gi];
    end
  endgenerate

  assign prng_valid = (state_q == ST_RUN);
  assign warm_busy  = (state_q == ST_WARM);

`ifdef LFSR_PERIOD_DET_EN
  // -------------------------------------------------------------------------
  // Period-wrap detector. start_q holds the up state present when RUN was
  // entered; a RUN step that lands back on it closes one full period.
  // -------------------------------------------------------------------------
  logic [UP_BITS-1:0] start_q, start_d;
  logic               wrap_q, wrap_d;
  logic               run_step, warm_done;

  always_comb begin
    run_step  = !seed_load && (state_q == ST_RUN) && prng_ready;
    warm_done = !seed_load && (state_q == ST_WARM) && (cnt_q == WARM_LAST);
    start_d   = start_q;
    wrap_d    = 1'b0;
    if (seed_load) begin
      // Without warm-up the loaded value is already the RUN entry state.
      if (WARMUP == 0) begin
        start_d = up_seeded;
      end
    end else if (warm_done) begin
      start_d = up_step;
    end else if (run_step && (up_step == start_q)) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= (WARMUP == 0) ? UP_INIT : '0;
      wrap_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      wrap_q  <= wrap_d;
    end
  end

  assign period_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_prng_gen.sv
module tb_lfsr_prng_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults with WARMUP=0
  logic        a_rst, a_load, a_ready;
  logic [15:0] a_su;
  logic [7:0]  a_sd;
  logic [7:0]  a_data;
  logic        a_valid, a_busy;
  // Instance B: defaults with WARMUP=32
  logic        b_rst, b_load, b_ready;
  logic [15:0] b_su;
  logic [7:0]  b_sd;
  logic [7:0]  b_data;
  logic        b_valid, b_busy;
`ifdef LFSR_PERIOD_DET_EN
  logic        a_wrap, b_wrap;
  logic        c_rst, c_load, c_ready;
  logic [3:0]  c_su, c_sd, c_data;
  logic        c_valid, c_busy, c_wrap;
`endif

  lfsr_prng_gen #(.WARMUP(0)) dut_a (
    .clk(clk), .rst(a_rst), .seed_up(a_su), .seed_down(a_sd),
    .seed_load(a_load), .prng_data(a_data), .prng_valid(a_valid),
    .prng_ready(a_ready), .warm_busy(a_busy)
`ifdef LFSR_PERIOD_DET_EN
    , .period_wrap(a_wrap)
`endif
  );

  lfsr_prng_gen #(.WARMUP(32)) dut_b (
    .clk(clk), .rst(b_rst), .seed_up(b_su), .seed_down(b_sd),
    .seed_load(b_load), .prng_data(b_data), .prng_valid(b_valid),
    .prng_ready(b_ready), .warm_busy(b_busy)
`ifdef LFSR_PERIOD_DET_EN
    , .period_wrap(b_wrap)
`endif
  );

`ifdef LFSR_PERIOD_DET_EN
  lfsr_prng_gen #(
    .UP_BITS(4), .DOWN_BITS(4), .OUT_BITS(4),
    .UP_TAPS(4'hC), .DOWN_TAPS(4'hC),
    .UP_INIT(4'h1), .DOWN_INIT(4'h1), .WARMUP(0)
  ) dut_c (
    .clk(clk), .rst(c_rst), .seed_up(c_su), .seed_down(c_sd),
    .seed_load(c_load), .prng_data(c_data), .prng_valid(c_valid),
    .prng_ready(c_ready), .warm_busy(c_busy), .period_wrap(c_wrap)
  );
`endif

  // Reference step for the default LFSRs
  function automatic logic [15:0] m_up(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
  function automatic logic [7:0] m_down(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        load;
    logic        ready;
    logic [15:0] su;
    logic [7:0]  sd;
    logic        exp_valid;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] mu;
    logic [7:0]  md;
    logic [7:0]  held;

    // rst, load, ready, seed_up, seed_down, exp_valid, exp_data
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hF0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hF0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'hE1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hE1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'hC2};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h85};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 8'h3C, 1'b1, 8'hC3};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h87};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 8'h3B};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h76};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h1234, 8'h55, 1'b1, 8'hF0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'hE1};

    a_rst = 1'b1; a_load = 1'b0; a_ready = 1'b0; a_su = '0; a_sd = '0;
    b_rst = 1'b1; b_load = 1'b0; b_ready = 1'b1; b_su = '0; b_sd = '0;
`ifdef LFSR_PERIOD_DET_EN
    c_rst = 1'b1; c_load = 1'b0; c_ready = 1'b1; c_su = '0; c_sd = '0;
`endif
    tick();

    // ---------------- Table: instance A (WARMUP=0) ----------------
    for (int i = 0; i < 12; i++) begin
      a_rst = tbl[i].rst; a_load = tbl[i].load; a_ready = tbl[i].ready;
      a_su = tbl[i].su; a_sd = tbl[i].sd;
      tick();
      check($sformatf("a_valid[%0d]", i), 32'(a_valid), 32'(tbl[i].exp_valid));
      check($sformatf("a_busy[%0d]", i), 32'(a_busy), 32'd0);
      check($sformatf("a_data[%0d]", i), 32'(a_data), 32'(tbl[i].exp_data));
      $display("vec %0d: rst=%0b load=%0b ready=%0b data=%02h exp=%02h",
               i, tbl[i].rst, tbl[i].load, tbl[i].ready, a_data, tbl[i].exp_data);
    end
    a_rst = 1'b0; a_load = 1'b0; a_ready = 1'b0;

    // ---------------- Instance B: warm-up after reset ----------------
    b_rst = 1'b1; tick();
    check("b_rst_data", 32'(b_data), 32'h0F0);
    b_rst = 1'b0;
    mu = 16'h00FF; md = 8'h0F;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("b_warm_valid[%0d]", i), 32'(b_valid), 32'd0);
      check($sformatf("b_warm_busy[%0d]", i), 32'(b_busy), 32'd1);
      tick();
      mu = m_up(mu); md = m_down(md);
    end
    check("b_run_valid", 32'(b_valid), 32'd1);
    check("b_run_busy", 32'(b_busy), 32'd0);
    check("b_warm_state", 32'(b_data), 32'(mu[7:0] ^ md));

    // Back-pressure: ten cycles with ready low must hold the word
    b_ready = 1'b0;
    held = mu[7:0] ^ md;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("b_hold[%0d]", i), 32'(b_data), 32'(held));
    end
    // Twenty accepted words, one per cycle, no skips or repeats
    b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("b_word[%0d]", i), 32'(b_data), 32'(mu[7:0] ^ md));
      tick();
      mu = m_up(mu); md = m_down(md);
    end

    // Zero up-seed mid-RUN with a concurrent handshake: load wins
    b_load = 1'b1; b_su = 16'h0000; b_sd = 8'h3C;
    tick();
    b_load = 1'b0;
    mu = 16'h00FF; md = 8'h3C;
    check("b_zseed_data", 32'(b_data), 32'hC3);
    check("b_zseed_busy", 32'(b_busy), 32'd1);
    check("b_zseed_valid", 32'(b_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      mu = m_up(mu); md = m_down(md);
    end
    check("b_midwarm_data", 32'(b_data), 32'(mu[7:0] ^ md));

    // Reload mid-WARM restarts the warm-up count
    b_load = 1'b1; b_su = 16'hABCD; b_sd = 8'h5A;
    tick();
    b_load = 1'b0;
    mu = 16'hABCD; md = 8'h5A;
    check("b_reload_data", 32'(b_data), 32'h97);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("b_rewarm_valid[%0d]", i), 32'(b_valid), 32'd0);
      tick();
      mu = m_up(mu); md = m_down(md);
    end
    check("b_rerun_valid", 32'(b_valid), 32'd1);
    check("b_rerun_data", 32'(b_data), 32'(mu[7:0] ^ md));

`ifdef LFSR_PERIOD_DET_EN
    // Period detector: 4-bit maximal LFSR wraps every 15 steps
    c_rst = 1'b1; tick();
    check("c_rst_wrap", 32'(c_wrap), 32'd0);
    c_rst = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check($sformatf("c_wrap[%0d]", i), 32'(c_wrap), 32'((i % 15) == 0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
